full_adder4_str: RTL and testbench

FULL_ADDER4_STR -- requirements
Module: full_adder4_str

---
 rtl/full_adder4_str.sv | 116 +++++++++++
 tb/tb_full_adder4_str.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/full_adder4_str.sv
// full_adder4_str: structural ripple-carry adder with a registered result.
// The adder is built from 1-bit full-adder cells. The cells are grouped into
// 4-bit ripple slices, and the slices are chained by carry. A single register
// stage holds SUM and Cout.
// Optional feature: define FULL_ADDER4_STR_OVF_EN to add a registered
// signed-overflow output, OVF.

// 1-bit full-adder cell
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ c;
    assign co = (a & b) | (a & c) | (b & c);
endmodule

// 4-bit ripple slice made of four fa_cell instances
module rca4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [4:0] c;

    assign c[0] = ci;
    assign co   = c[4];

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_bit
            fa_cell u_fa (
                .a  (a[i]),
                .b  (b[i]),
                .c  (c[i]),
                .s  (s[i]),
                .co (c[i+1])
            );
        end
    endgenerate
endmodule

module full_adder4_str #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] SUM,
`ifdef FULL_ADDER4_STR_OVF_EN
    output logic             OVF,
`endif
    output logic             Cout
);
    localparam int NSLICE = WIDTH / 4;

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
            $error("full_adder4_str: WIDTH must be a multiple of 4, minimum 4");
        end
    endgenerate

    logic [NSLICE:0]  carry;
    logic [WIDTH-1:0] s;
    logic             c_out;

    assign carry[0] = Cin;
    assign c_out    = carry[NSLICE];

    genvar k;
    generate
        for (k = 0; k < NSLICE; k++) begin : g_slice
            rca4_slice u_slice (
                .a  (A[4*k +: 4]),
                .b  (B[4*k +: 4]),
                .ci (carry[k]),
                .s  (s[4*k +: 4]),
                .co (carry[k+1])
            );
        end
    endgenerate

    // Result register: 1-cycle latency, no handshake, async clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SUM  <= '0;
            Cout <= 1'b0;
        end else begin
            SUM  <= s;
            Cout <= c_out;
        end
    end

`ifdef FULL_ADDER4_STR_OVF_EN
    // The carry into the MSB cell is recovered from that cell's own sum bit,
    // because s = a^b^c implies c = a^b^s. This avoids exposing
    // per-slice internal carries.
    logic c_into_msb;
    logic ovf_c;

    assign c_into_msb = A[WIDTH-1] ^ B[WIDTH-1] ^ s[WIDTH-1];
    assign ovf_c      = c_into_msb ^ c_out;

    // Signed-overflow register, aligned with SUM/Cout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) OVF <= 1'b0;
        else        OVF <= ovf_c;
    end
`endif
endmodule

// File: tb/tb_full_adder4_str.sv
// Self-checking bench for full_adder4_str (WIDTH=32).
// Directed vectors cover the basic function, the carry-out boundaries and
// asynchronous reset. A random run follows. Expected values come from plain
// integer arithmetic in the bench.
module tb_full_adder4_str;
    logic        clk;
    logic        rst_n;
    logic [31:0] a, b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
`ifdef FULL_ADDER4_STR_OVF_EN
    logic        ovf;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    full_adder4_str #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (a),
        .B     (b),
        .Cin   (cin),
        .SUM   (sum),
`ifdef FULL_ADDER4_STR_OVF_EN
        .OVF   (ovf),
`endif
        .Cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: exact sum with a 33-bit result, plus a signed range check
    task automatic check_model(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                               input logic ic);
        logic [32:0] full;
        longint      ss;
        logic        exp_ovf;
        full    = {1'b0, ia} + {1'b0, ib} + {32'd0, ic};
        ss      = longint'($signed(ia)) + longint'($signed(ib)) + longint'(ic);
        exp_ovf = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
        chk({tag, ".sum"},  {32'd0, sum},  {32'd0, full[31:0]});
        chk({tag, ".cout"}, {63'd0, cout}, {63'd0, full[32]});
`ifdef FULL_ADDER4_STR_OVF_EN
        chk({tag, ".ovf"},  {63'd0, ovf},  {63'd0, exp_ovf});
`else
        if (exp_ovf === 1'bx) $display("model produced unknown overflow");
`endif
    endtask

    // Drive one vector at negedge, then check the registered result just after the next posedge
    task automatic step(input logic [31:0] ia, input logic [31:0] ib, input logic ic,
                        input string tag);
        @(negedge clk);
        a = ia; b = ib; cin = ic;
        @(posedge clk);
        #1;
        check_model(tag, ia, ib, ic);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".sum"},  {32'd0, sum},  64'd0);
        chk({tag, ".cout"}, {63'd0, cout}, 64'd0);
`ifdef FULL_ADDER4_STR_OVF_EN
        chk({tag, ".ovf"},  {63'd0, ovf},  64'd0);
`endif
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rc;

        rst_n = 1'b0;
        a = 32'hDEAD_BEEF; b = 32'h1234_5678; cin = 1'b1;
        #1;
        chk_zero("reset_async");
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset_edges");

        // The first edge after release captures the live inputs
        @(negedge clk);
        rst_n = 1'b1;
        a = 32'd16; b = 32'd11; cin = 1'b0;
        @(posedge clk);
        #1;
        chk({"first.sum"}, {32'd0, sum}, 64'd27);
        chk({"first.cout"}, {63'd0, cout}, 64'd0);

        step(32'd25, 32'd11, 1'b0, "seq36");
        chk("seq36.lit", {32'd0, sum}, 64'd36);
        step(32'd25, 32'd12, 1'b0, "seq37");
        chk("seq37.lit", {32'd0, sum}, 64'd37);
        step(32'd3,  32'd12, 1'b0, "seq15");
        chk("seq15.lit", {32'd0, sum}, 64'd15);
        step(32'd3,  32'd3,  1'b0, "seq6");
        chk("seq6.lit", {32'd0, sum}, 64'd6);

        // Wrap-around boundaries
        step(32'hFFFF_FFFF, 32'd0, 1'b1, "wrap0");
        chk("wrap0.lit", {31'd0, cout, sum}, 64'h1_0000_0000);
        step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "allones");
        chk("allones.lit", {31'd0, cout, sum}, 64'h1_FFFF_FFFF);
        step(32'h7FFF_FFFF, 32'd1, 1'b0, "sovf");
        chk("sovf.lit", {31'd0, cout, sum}, 64'h0_8000_0000);
        step(32'h8000_0000, 32'h8000_0000, 1'b0, "negovf");

        // Inputs that change between edges must not disturb the outputs
        step(32'd100, 32'd23, 1'b1, "hold");
        a = 32'hFFFF_0000; b = 32'h0F0F_0F0F; cin = 1'b0;
        #3;
        chk("hold.mid", {32'd0, sum}, 64'd124);

        // Assert reset mid-operation while SUM=37
        step(32'd25, 32'd12, 1'b0, "pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        a = 32'd1000; b = 32'd2000; cin = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        a = 32'd40; b = 32'd2; cin = 1'b1;
        @(posedge clk);
        #1;
        check_model("rst_release", 32'd40, 32'd2, 1'b1);
        chk("rst_release.lit", {32'd0, sum}, 64'd43);

        // Back-to-back random vectors, one per cycle
        for (int i = 0; i < 10000; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            if (i % 97 == 0) ra = 32'hFFFF_FFFF;
            if (i % 89 == 0) rb = 32'h8000_0000;
            step(ra, rb, rc, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
